// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// The bypass option is enabled by defining REGFILE_WB_BYPASS_EN.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins,
// and the pointer moves past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         ctrl_reset_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic          found;
  int            win;
  int            idx;

  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    win     = 0;
    idx     = 0;
    nxt_ptr = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      gnt[win] = 1'b1;
      nxt_ptr  = PW'((win + 1) % N);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between requesters via a
// one-entry write stage. Optional bypass: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]  req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_hold,
  output logic                           ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]          ctrl_writeReg,
  output logic [DATA_W-1:0]              data_writeReg,
  output logic [CNT_W-1:0]               wr_count,
  output logic                           idle
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]          byp_readRegA,
  input  logic [REG_ADDR_W-1:0]          byp_readRegB,
  output logic                           byp_hitA,
  output logic                           byp_hitB,
  output logic [DATA_W-1:0]              byp_dataA,
  output logic [DATA_W-1:0]              byp_dataB
`endif
);

  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  logic               stage_full;
  wb_req_t            sel;
  wb_req_t            stage;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .req          (req_valid),
    .en           (~wb_hold),
    .gnt          (gnt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.rd   = req_reg[REG_ADDR_W*i +: REG_ADDR_W];
        sel.data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign any_gnt   = |gnt;
  assign req_ready = gnt;

  // Writes to x0 are consumed but never occupy the stage.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      stage_full <= 1'b0;
      stage      <= '0;
    end else if (!wb_hold) begin
      if (any_gnt && sel.rd != ZERO_REG) begin
        stage_full <= 1'b1;
        stage      <= sel;
      end else begin
        stage_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_count <= '0;
    end else if (ctrl_writeEnable) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  assign ctrl_writeEnable = stage_full & ~wb_hold;
  assign ctrl_writeReg    = stage.rd;
  assign data_writeReg    = stage.data;
  assign idle             = ~stage_full & ~|req_valid;

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    byp_hitA  = ctrl_writeEnable && (byp_readRegA == ctrl_writeReg)
                && (byp_readRegA != ZERO_REG);
    byp_hitB  = ctrl_writeEnable && (byp_readRegB == ctrl_writeReg)
                && (byp_readRegB != ZERO_REG);
    byp_dataA = byp_hitA ? data_writeReg : '0;
    byp_dataB = byp_hitB ? data_writeReg : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Bypass checks are built when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int CW = 16;

  logic            clock;
  logic            ctrl_reset_n;
  logic [NR-1:0]   req_valid;
  logic [5*NR-1:0] req_reg;
  logic [32*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            wb_hold;
  logic            ctrl_writeEnable;
  logic [4:0]      ctrl_writeReg;
  logic [31:0]     data_writeReg;
  logic [CW-1:0]   wr_count;
  logic            idle;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]      byp_readRegA;
  logic [4:0]      byp_readRegB;
  logic            byp_hitA;
  logic            byp_hitB;
  logic [31:0]     byp_dataA;
  logic [31:0]     byp_dataB;
`endif

  int passed;
  int total;

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .CNT_W   (CW)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .wb_hold          (wb_hold),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wr_count         (wr_count),
    .idle             (idle)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .byp_readRegA     (byp_readRegA),
    .byp_readRegB     (byp_readRegB),
    .byp_hitA         (byp_hitA),
    .byp_hitB         (byp_hitB),
    .byp_dataA        (byp_dataA),
    .byp_dataB        (byp_dataB)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] r, input logic [31:0] d);
    req_valid[i]       = v;
    req_reg[5*i +: 5]  = r;
    req_data[32*i +: 32] = d;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    req_valid    = '0;
    req_reg      = '0;
    req_data     = '0;
    wb_hold      = 1'b0;
    cyc();
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    req_valid    = '0;
    req_reg      = '0;
    req_data     = '0;
    wb_hold      = 1'b0;
    #2;
    total++;
    if (ctrl_writeEnable !== 1'b0)
      $display("FAIL reset_we got %b want 0", ctrl_writeEnable);
    else passed++;
    total++;
    if (ctrl_writeReg !== 5'd0)
      $display("FAIL reset_reg got %0d want 0", ctrl_writeReg);
    else passed++;
    total++;
    if (data_writeReg !== 32'd0)
      $display("FAIL reset_data got %h want 0", data_writeReg);
    else passed++;
    total++;
    if (wr_count !== 16'd0)
      $display("FAIL reset_count got %0d want 0", wr_count);
    else passed++;
    total++;
    if (req_ready !== 3'b000)
      $display("FAIL reset_ready got %b want 000", req_ready);
    else passed++;
    total++;
    if (idle !== 1'b1)
      $display("FAIL reset_idle got %b want 1", idle);
    else passed++;
    cyc();
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL single_ready got %b want 001", req_ready);
    else passed++;
    total++;
    if (idle !== 1'b0)
      $display("FAIL single_idle_busy got %b want 0", idle);
    else passed++;
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 ||
        data_writeReg !== 32'hDEADBEEF)
      $display("FAIL single_write got we=%b reg=%0d data=%h want 1/5/deadbeef",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
    total++;
    if (wr_count !== 16'd0)
      $display("FAIL single_count_pre got %0d want 0", wr_count);
    else passed++;
    cyc();
    #1;
    total++;
    if (wr_count !== 16'd1)
      $display("FAIL single_count got %0d want 1", wr_count);
    else passed++;
    total++;
    if (ctrl_writeEnable !== 1'b0 || idle !== 1'b1)
      $display("FAIL single_drain got we=%b idle=%b want 0/1",
               ctrl_writeEnable, idle);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 3; i++)
      set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rdy = 3'b001 << (k % 3);
      total++;
      if (req_ready !== exp_rdy)
        $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy);
      else passed++;
      if (k > 0) begin
        total++;
        if (ctrl_writeEnable !== 1'b1 ||
            ctrl_writeReg !== 5'(((k - 1) % 3) + 1))
          $display("FAIL rr_write[%0d] got we=%b reg=%0d want 1/%0d",
                   k, ctrl_writeEnable, ctrl_writeReg, ((k - 1) % 3) + 1);
        else passed++;
      end
      cyc();
    end
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 ||
        data_writeReg !== 32'h102)
      $display("FAIL rr_last got we=%b reg=%0d data=%h want 1/3/102",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
    cyc();
    #1;
    total++;
    if (wr_count !== 16'd6)
      $display("FAIL rr_count got %0d want 6", wr_count);
    else passed++;
  endtask

  task automatic test_same_dest();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h11);
    set_req(2, 1'b1, 5'd7, 32'h22);
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL same_ready0 got %b want 001", req_ready);
    else passed++;
    cyc();
    req_valid[0] = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b100)
      $display("FAIL same_ready2 got %b want 100", req_ready);
    else passed++;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 ||
        data_writeReg !== 32'h11)
      $display("FAIL same_first got we=%b reg=%0d data=%h want 1/7/11",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 ||
        data_writeReg !== 32'h22)
      $display("FAIL same_second got we=%b reg=%0d data=%h want 1/7/22",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
  endtask

  task automatic test_reg0();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h77);
    #1;
    total++;
    if (req_ready !== 3'b010)
      $display("FAIL reg0_ready got %b want 010", req_ready);
    else passed++;
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b0)
      $display("FAIL reg0_we got %b want 0", ctrl_writeEnable);
    else passed++;
    cyc();
    #1;
    total++;
    if (wr_count !== 16'd0)
      $display("FAIL reg0_count got %0d want 0", wr_count);
    else passed++;
  endtask

  task automatic test_hold();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h55);
    cyc();
    set_req(0, 1'b1, 5'd11, 32'h77);
    set_req(1, 1'b1, 5'd10, 32'h66);
    wb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (ctrl_writeEnable !== 1'b0 || req_ready !== 3'b000)
        $display("FAIL hold[%0d] got we=%b ready=%b want 0/000",
                 k, ctrl_writeEnable, req_ready);
      else passed++;
      cyc();
    end
    wb_hold = 1'b0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 ||
        data_writeReg !== 32'h55)
      $display("FAIL hold_release got we=%b reg=%0d data=%h want 1/9/55",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
    total++;
    if (req_ready !== 3'b010)
      $display("FAIL hold_ready got %b want 010", req_ready);
    else passed++;
    total++;
    if (wr_count !== 16'd0)
      $display("FAIL hold_count_pre got %0d want 0", wr_count);
    else passed++;
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd10 ||
        data_writeReg !== 32'h66)
      $display("FAIL hold_next got we=%b reg=%0d data=%h want 1/10/66",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    else passed++;
    total++;
    if (wr_count !== 16'd1)
      $display("FAIL hold_count got %0d want 1", wr_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 5'd12, 32'hAB);
    cyc();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd13, 32'hCD);
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd13 ||
        wr_count !== 16'd1)
      $display("FAIL mid_pre got we=%b reg=%0d cnt=%0d want 1/13/1",
               ctrl_writeEnable, ctrl_writeReg, wr_count);
    else passed++;
    ctrl_reset_n = 1'b0;
    #1;
    total++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 ||
        wr_count !== 16'd0)
      $display("FAIL mid_reset got we=%b reg=%0d cnt=%0d want 0/0/0",
               ctrl_writeEnable, ctrl_writeReg, wr_count);
    else passed++;
    cyc();
    ctrl_reset_n = 1'b1;
    set_req(0, 1'b1, 5'd14, 32'hEE);
    set_req(1, 1'b1, 5'd15, 32'hFF);
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL mid_ptr got %b want 001", req_ready);
    else passed++;
    total++;
    if (ctrl_writeEnable !== 1'b0 || wr_count !== 16'd0)
      $display("FAIL mid_discard got we=%b cnt=%0d want 0/0",
               ctrl_writeEnable, wr_count);
    else passed++;
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (ctrl_writeReg !== 5'd14 || wr_count !== 16'd0)
      $display("FAIL mid_after got reg=%0d cnt=%0d want 14/0",
               ctrl_writeReg, wr_count);
    else passed++;
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    byp_readRegA = 5'd4;
    byp_readRegB = 5'd0;
    set_req(0, 1'b1, 5'd4, 32'hA5A5A5A5);
    cyc();
    req_valid = '0;
    #1;
    total++;
    if (byp_hitA !== 1'b1 || byp_dataA !== 32'hA5A5A5A5)
      $display("FAIL byp_a got hit=%b data=%h want 1/a5a5a5a5",
               byp_hitA, byp_dataA);
    else passed++;
    total++;
    if (byp_hitB !== 1'b0 || byp_dataB !== 32'd0)
      $display("FAIL byp_b got hit=%b data=%h want 0/0", byp_hitB, byp_dataB);
    else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
`ifdef REGFILE_WB_BYPASS_EN
    byp_readRegA = '0;
    byp_readRegB = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_same_dest();
    test_reg0();
    test_hold();
    test_reset_mid();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
